// File: rtl/reg_file_sb_if.sv
// Register-file / scoreboard bus.
// Groups the read ports, the write-back port, the issue port and the hazard
// outputs into one bundle.
//   master : the pipeline side; drives addresses, write-back and issue, and
//            observes the read data, stall and busy vector.
//   slave  : the register file itself.
interface reg_file_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  localparam int unsigned NumRegs = 2 ** ADDR_W;

  // Read ports
  logic [ADDR_W-1:0]  rd_addr1;
  logic [ADDR_W-1:0]  rd_addr2;
  logic [DATA_W-1:0]  rd_data1;
  logic [DATA_W-1:0]  rd_data2;

  // Write-back port
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;

  // Issue port
  logic               iss_en;
  logic [ADDR_W-1:0]  iss_addr;

  // Hazard status
  logic               stall;
  logic [NumRegs-1:0] busy_vec;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data1, rd_data2, stall, busy_vec
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data1, rd_data2, stall, busy_vec
  );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with a per-register busy scoreboard.
//   clk   : single clock, all state updates on its rising edge
//   rst_n : synchronous active-low reset; clears registers and busy bits
//   bus   : reg_file_sb_if slave modport
//     rd_addr1/2, rd_data1/2 : combinational read ports with write-through
//     wr_en/wr_addr/wr_data  : write-back; also clears the busy bit
//     iss_en/iss_addr        : issue; marks the destination busy
//     stall                  : an operand read hits a pending register
//     busy_vec               : scoreboard, bit i = register i pending
// Register 0 reads as zero and is never written or marked busy.
module reg_file_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_sb_if.slave  bus
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0]  regs_q [NumRegs];
  logic [DATA_W-1:0]  regs_d [NumRegs];
  logic [NumRegs-1:0] busy_q;
  logic [NumRegs-1:0] busy_d;

  logic wr_act;
  logic iss_act;
  logic byp1;
  logic byp2;

  // Writes and issues to r0 are discarded; both are also dead during reset
  // so the read bypass cannot leak write data while rst_n is low.
  always_comb begin
    wr_act  = rst_n && bus.wr_en && (bus.wr_addr != '0);
    iss_act = rst_n && bus.iss_en && (bus.iss_addr != '0);
    byp1    = wr_act && (bus.wr_addr == bus.rd_addr1);
    byp2    = wr_act && (bus.wr_addr == bus.rd_addr2);
  end

  // Next state. The issue update is applied after the write-back clear so
  // that a same-index issue and write-back leaves the register busy: the
  // newly issued producer owns it.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_act) begin
      regs_d[bus.wr_addr] = bus.wr_data;
      busy_d[bus.wr_addr] = 1'b0;
    end
    if (iss_act) begin
      busy_d[bus.iss_addr] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports: zero latency, write-through on an address match.
  always_comb begin
    bus.rd_data1 = '0;
    bus.rd_data2 = '0;
    if (rst_n && (bus.rd_addr1 != '0)) begin
      bus.rd_data1 = byp1 ? bus.wr_data : regs_q[bus.rd_addr1];
    end
    if (rst_n && (bus.rd_addr2 != '0)) begin
      bus.rd_data2 = byp2 ? bus.wr_data : regs_q[bus.rd_addr2];
    end
  end

  // A port being fed by this cycle's write-back has its operand available,
  // so it does not contribute to stall.
  always_comb begin
    bus.stall    = rst_n && ((busy_q[bus.rd_addr1] && !byp1) ||
                             (busy_q[bus.rd_addr2] && !byp2));
    bus.busy_vec = rst_n ? busy_q : '0;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  logic clk;
  logic rst_n;

  reg_file_sb_if bus ();

  reg_file_sb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_err;

  // Reference model: plain arrays holding register contents and pending flags.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  // Values observed in the most recent step, before its clock edge.
  logic [31:0] obs_d1;
  logic [31:0] obs_d2;
  logic        obs_stall;
  logic [31:0] obs_busy;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare combinational outputs against the
  // model before the edge, then let the edge happen and advance the model.
  task automatic step(input logic rst, input logic [4:0] a1, input logic [4:0] a2,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ie, input logic [4:0] ia);
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        e_stall;
    logic [31:0] e_busy;
    bit          wvalid;
    bit          need1;
    bit          need2;

    @(negedge clk);
    rst_n        = rst;
    bus.rd_addr1 = a1;
    bus.rd_addr2 = a2;
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.iss_en   = ie;
    bus.iss_addr = ia;
    #1;

    wvalid = rst && we && (wa != 0);
    if (!rst) begin
      e_d1 = 0; e_d2 = 0; e_stall = 0; e_busy = 0;
    end else begin
      if (a1 == 0)                    e_d1 = 0;
      else if (wvalid && wa == a1)    e_d1 = wd;
      else                            e_d1 = m_regs[a1];
      if (a2 == 0)                    e_d2 = 0;
      else if (wvalid && wa == a2)    e_d2 = wd;
      else                            e_d2 = m_regs[a2];
      need1   = m_busy[a1] && !(wvalid && wa == a1);
      need2   = m_busy[a2] && !(wvalid && wa == a2);
      e_stall = need1 || need2;
      e_busy  = 0;
      for (int i = 0; i < 32; i++) e_busy[i] = m_busy[i];
    end

    obs_d1    = bus.rd_data1;
    obs_d2    = bus.rd_data2;
    obs_stall = bus.stall;
    obs_busy  = bus.busy_vec;
    check_eq("rd_data1", 64'(obs_d1), 64'(e_d1));
    check_eq("rd_data2", 64'(obs_d2), 64'(e_d2));
    check_eq("stall", 64'(obs_stall), 64'(e_stall));
    check_eq("busy_vec", 64'(obs_busy), 64'(e_busy));

    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 0;
        m_busy[i] = 0;
      end
    end else begin
      if (wvalid) begin
        m_regs[wa] = wd;
        m_busy[wa] = 0;
      end
      if (ie && ia != 0) m_busy[ia] = 1;
    end
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.iss_en = 1'b0; bus.iss_addr = '0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 0;
      m_busy[i] = 0;
    end

    // Reset, then every index on both ports reads zero with nothing pending.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step(1, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0);
      check_eq("rst_rd1_zero", 64'(obs_d1), 64'h0);
      check_eq("rst_rd2_zero", 64'(obs_d2), 64'h0);
      check_eq("rst_busy_zero", 64'(obs_busy), 64'h0);
    end

    // Write r5 then read it; writes to r0 are dropped.
    step(1, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0, 0);
    check_eq("r5_read", 64'(obs_d1), 64'hDEADBEEF);
    step(1, 0, 0, 1, 0, 32'h1234, 0, 0);
    check_eq("r0_bypass_none", 64'(obs_d1), 64'h0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("r0_read", 64'(obs_d1), 64'h0);

    // Write-through on port 2, then the register holds the value.
    step(1, 0, 7, 1, 7, 32'hCAFEF00D, 0, 0);
    check_eq("r7_bypass", 64'(obs_d2), 64'hCAFEF00D);
    step(1, 0, 7, 0, 0, 0, 0, 0);
    check_eq("r7_held", 64'(obs_d2), 64'hCAFEF00D);

    // Issue r3, stall on read, write-back bypass removes stall, busy clears.
    step(1, 0, 0, 0, 0, 0, 1, 3);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    check_eq("r3_stall", 64'(obs_stall), 64'h1);
    check_eq("r3_busy", 64'(obs_busy[3]), 64'h1);
    step(1, 3, 0, 1, 3, 32'h55, 0, 0);
    check_eq("r3_byp_nostall", 64'(obs_stall), 64'h0);
    check_eq("r3_byp_data", 64'(obs_d1), 64'h55);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("r3_cleared", 64'(obs_busy[3]), 64'h0);

    // Same-index issue and write: data lands, register stays busy.
    step(1, 0, 0, 1, 9, 32'hAA, 1, 9);
    step(1, 9, 0, 0, 0, 0, 0, 0);
    check_eq("r9_data", 64'(obs_d1), 64'hAA);
    check_eq("r9_busy", 64'(obs_busy[9]), 64'h1);
    // Different indices, writing a non-busy register.
    step(1, 0, 0, 1, 6, 32'h66, 1, 4);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("r4_busy", 64'(obs_busy[4]), 64'h1);
    check_eq("r6_not_busy", 64'(obs_busy[6]), 64'h0);

    // Reset mid-operation drops pending entries and ignores concurrent ops.
    step(1, 0, 0, 0, 0, 0, 1, 10);
    step(1, 0, 0, 0, 0, 0, 1, 11);
    step(0, 10, 11, 1, 10, 32'h77, 1, 12);
    check_eq("inrst_rd1", 64'(obs_d1), 64'h0);
    check_eq("inrst_stall", 64'(obs_stall), 64'h0);
    check_eq("inrst_busy", 64'(obs_busy), 64'h0);
    step(1, 10, 11, 0, 0, 0, 0, 0);
    check_eq("postrst_busy", 64'(obs_busy), 64'h0);
    check_eq("postrst_r10", 64'(obs_d1), 64'h0);
    check_eq("postrst_r11", 64'(obs_d2), 64'h0);
    check_eq("postrst_stall", 64'(obs_stall), 64'h0);

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 59) != 0), rnd_addr(), rnd_addr(),
           ($urandom_range(0, 1) == 1), rnd_addr(), $urandom(),
           ($urandom_range(0, 9) < 4), rnd_addr());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
